fesub: RTL and testbench
========================

Name: fesub

Overview:
- Word-serial modular subtractor over GF(2^255-19): out = (a - b) mod P.
- Same limb geometry as the field adder: 15 limbs of 17 bits, one limb per clock, least-significant limb first.
- Computes the raw difference and the difference plus P in parallel, then selects on the final borrow.
- Sits next to the field adder in the curve25519 datapath and shares its start/done handshake, so a sequencer can drive either unit interchangeably.

Parameters:
- W, 17, limb width in bits (hardware multiplier input word size).
- N, 15, number of limbs per field element; N*W = 255.
- C, 19, pseudo-Mersenne coefficient.
- P, (1<<(N*W)) - C, field modulus 2^255-19.
- LOGN, 4, width of the limb index counter; must satisfy 2^LOGN > N.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; operands are sampled on the same edge.
- a_in  input  255  minuend, sampled when start=1.
- b_in  input  255  subtrahend, sampled when start=1.
- busy  output  1  high while limbs are being processed.
- done  output  1  one-cycle pulse; result is valid from this cycle onward.
- out  output  255  result, held stable until the first limb edge of the next operation.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - done=0, busy=0, out=0;
  - limb index i=N (idle);
  - borrow=0, carryP=0, select=0;
  - operand and partial-result registers = 0.
- Release of reset is not an operation: no done pulse follows it.
- start=1 on edge E0:
  - latch a_in and b_in;
  - i<=0, borrow<=0, carryP<=0, busy<=1.
- Limb edges E(k+1), k = 0..N-1, while i<N:
  - diff = a[k] - b[k] - borrow, (W+1)-bit; diff[W] is the new borrow.
  - sumP = diff[W-1:0] + P[k] + carryP, (W+1)-bit; sumP[W] is the new carryP.
  - Shift diff[W-1:0] into the top of the raw shift register and sumP[W-1:0] into the top of the P-adjusted shift register; both shift right by W.
  - i<=i+1.
- At edge EN (k=N-1):
  - select<=final borrow (diff[W]); done<=1; busy<=0.
  - The final carryP is discarded.
- out = P-adjusted register when select=1, else raw register.
- Result definition: out = (a - b + (a<b ? P : 0)) mod 2^255.
  - Canonical (< P) whenever both inputs are < P.
  - For inputs in [P, 2^255) the value is defined by that formula, no further reduction.
- Latency: done is high in the cycle after EN, i.e. N cycles after the start edge. Throughput: one operation per N+1 cycles when start is re-issued on the done cycle.
- done is exactly one cycle wide; it clears on the next edge unless that edge also completes an operation (impossible, since an operation takes N edges).
- start while busy: abort the current operation and restart with the new operands. No done pulse is produced for the aborted operation.
- start in the done cycle: accepted normally. done drops on that edge, and out remains valid until the first limb edge after it.
- start held high for several cycles: each cycle restarts the operation; the operation effectively begins at the last start edge.
- Reset mid-operation: immediate return to reset values, no done pulse; the next start behaves as from cold.
- Idle (i=N, no start): all registers hold; out stays stable indefinitely.

Decomposition:
- Shared package fe_pkg, common with the field adder:
  - constants W, N, C, LOGN;
  - the 255-bit modulus P;
  - a limb-select helper function (limb k of a 255-bit vector).
- No sub-module is needed. The per-limb subtract/add-back is about two lines of combinational logic and stays inline. The limb counter plus two shift registers keep the RTL in the 120-200 line range.

Test Plan:
- a=5, b=3, start one cycle → done exactly 15 cycles later, out=2, busy high for those 15 cycles.
- a=3, b=5 → out = 2^255-21 (P-2), i.e. select=1.
- a=0, b=1 → out = P-1. Also a=P-1, b=P-1 → out=0, and a=0, b=0 → out=0.
- a=2^17, b=1 → borrow propagates across the limb boundary: out = 0x1FFFF (limb0 = 0x1FFFF, limb1 = 0), select=0.
- start (a=9, b=4), then a second start 7 cycles later (a=1, b=2) → single done, 15 cycles after the second start, out=P-1.
- reset asserted at cycle 8 of an operation → done, busy and out go to 0 asynchronously, no done pulse follows; a subsequent start with a=7, b=7 → out=0.
- Back-to-back: start re-issued in each done cycle with random a, b < P, 1000 iterations → every out equals (a-b) mod P from the reference model.

Source files
------------

// File: rtl/fe_pkg.sv
// Field-element geometry and modulus for GF(2^255-19), shared by the limb-serial adder and subtractor.
package fe_pkg;

  localparam int W    = 17;
  localparam int N    = 15;
  localparam int C    = 19;
  localparam int LOGN = 4;

  // 2^255 - 19 == ~(19 - 1) within 255 bits
  localparam logic [N*W-1:0] P = ~((N*W)'(C - 1));

  localparam logic [LOGN-1:0] LIMB_LAST = LOGN'(N - 1);
  localparam logic [LOGN-1:0] LIMB_IDLE = LOGN'(N);

  function automatic logic [W-1:0] limb(input logic [N*W-1:0] v, input logic [LOGN-1:0] k);
    logic [N*W-1:0] s;
    s = v >> (int'(k) * W);
    return s[W-1:0];
  endfunction

endpackage

// File: rtl/fesub.sv
// Limb-serial modular subtractor: out = (a - b) mod 2^255-19, raw and +P paths in parallel.
// Latency N cycles start->done; no backpressure, start at any time restarts the operation.
module fesub
  import fe_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [N*W-1:0]   a_in,
  input  logic [N*W-1:0]   b_in,
  output logic             busy,
  output logic             done,
  output logic [N*W-1:0]   out
);

  logic [N*W-1:0]  a_r;
  logic [N*W-1:0]  b_r;
  logic [N*W-1:0]  raw_r;
  logic [N*W-1:0]  adj_r;
  logic [LOGN-1:0] idx;
  logic            borrow;
  logic            carry_p;
  logic            select;
  logic [W:0]      diff;
  logic [W:0]      sum_p;

  always_comb begin
    diff  = {1'b0, limb(a_r, idx)} - {1'b0, limb(b_r, idx)} - {{W{1'b0}}, borrow};
    sum_p = {1'b0, diff[W-1:0]} + {1'b0, limb(P, idx)} + {{W{1'b0}}, carry_p};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_r     <= '0;
      b_r     <= '0;
      raw_r   <= '0;
      adj_r   <= '0;
      idx     <= LIMB_IDLE;
      borrow  <= 1'b0;
      carry_p <= 1'b0;
      select  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (start) begin
      a_r     <= a_in;
      b_r     <= b_in;
      idx     <= '0;
      borrow  <= 1'b0;
      carry_p <= 1'b0;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (idx != LIMB_IDLE) begin
        borrow  <= diff[W];
        carry_p <= sum_p[W];
        raw_r   <= {diff[W-1:0], raw_r[N*W-1:W]};
        adj_r   <= {sum_p[W-1:0], adj_r[N*W-1:W]};
        idx     <= idx + 1'b1;
        // final borrow means a < b, so the P-adjusted value is the answer
        if (idx == LIMB_LAST) begin
          select <= diff[W];
          done   <= 1'b1;
          busy   <= 1'b0;
        end
      end
    end
  end

  assign out = select ? adj_r : raw_r;

endmodule

// File: tb/tb_fesub.sv
// Scoreboard bench for fesub: driver pushes expected results, negedge monitor pops on done.
module tb_fesub;
  import fe_pkg::*;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [N*W-1:0] a_in  = '0;
  logic [N*W-1:0] b_in  = '0;
  logic           busy;
  logic           done;
  logic [N*W-1:0] out;

  int checks = 0;
  int errors = 0;
  logic [N*W-1:0] exp_q[$];

  fesub dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clock = ~clock;

  function automatic logic [N*W-1:0] ref_sub(input logic [N*W-1:0] a, input logic [N*W-1:0] b);
    if (a >= b) return a - b;
    return a - b + P;
  endfunction

  function automatic logic [N*W-1:0] rand_fe();
    logic [N*W-1:0] x;
    x = '0;
    for (int w = 0; w < 8; w++) x = (x << 32) | (N*W)'($urandom());
    if (x >= P) x = x - P;
    return x;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done out=%h", out);
      end else begin
        logic [N*W-1:0] e;
        e = exp_q.pop_front();
        if (out !== e) begin
          errors++;
          $display("FAIL result got=%h exp=%h", out, e);
        end
      end
    end
  end

  // Called at a negedge; issues start there and returns at the negedge of the done cycle.
  task automatic run_op(input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                        input logic [N*W-1:0] exp, input logic expect_done);
    int k;
    int busy_cnt;
    logic busy_at_done;
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    if (expect_done) exp_q.push_back(exp);
    @(posedge clock);
    #1 start = 1'b0;
    k = 0;
    busy_cnt = 0;
    @(negedge clock);
    while (!done && k < 40) begin
      if (busy) busy_cnt++;
      @(posedge clock);
      k++;
      @(negedge clock);
    end
    busy_at_done = busy;
    checks++;
    if (k != N || !done) begin
      errors++;
      $display("FAIL latency got=%0d exp=%0d done=%b", k, N, done);
    end
    checks++;
    if (busy_cnt != N || busy_at_done !== 1'b0) begin
      errors++;
      $display("FAIL busy_window got=%0d exp=%0d busy_at_done=%b", busy_cnt, N, busy_at_done);
    end
  endtask

  initial begin
    logic [N*W-1:0] ra;
    logic [N*W-1:0] rb;
    int stable_bad;

    repeat (3) @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL reset_state done=%b busy=%b out=%h exp 0/0/0", done, busy, out);
    end
    reset = 1'b0;
    repeat (4) @(negedge clock);

    run_op(255'd5, 255'd3, 255'd2, 1'b1);
    @(negedge clock);
    stable_bad = 0;
    repeat (5) begin
      if (out !== 255'd2 || busy !== 1'b0 || done !== 1'b0) stable_bad++;
      @(negedge clock);
    end
    checks++;
    if (stable_bad != 0) begin
      errors++;
      $display("FAIL idle_hold bad_cycles=%0d exp 0 out=%h", stable_bad, out);
    end

    run_op(255'd3, 255'd5, P - 255'd2, 1'b1);
    @(negedge clock);
    run_op(255'd0, 255'd1, P - 255'd1, 1'b1);
    @(negedge clock);
    run_op(P - 255'd1, P - 255'd1, 255'd0, 1'b1);
    @(negedge clock);
    run_op(255'd0, 255'd0, 255'd0, 1'b1);
    @(negedge clock);
    run_op(255'h20000, 255'd1, 255'h1FFFF, 1'b1);
    @(negedge clock);

    // Abort: second start 7 edges after the first; only one done expected.
    start = 1'b1;
    a_in  = 255'd9;
    b_in  = 255'd4;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    run_op(255'd1, 255'd2, P - 255'd1, 1'b1);
    @(negedge clock);

    // Reset at cycle 8 of an operation, checked between clock edges.
    start = 1'b1;
    a_in  = {8{32'hDEADBEEF}};
    b_in  = 255'd12345;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (8) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out !== '0) begin
      errors++;
      $display("FAIL async_reset done=%b busy=%b out=%h exp 0/0/0", done, busy, out);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    run_op(255'd7, 255'd7, 255'd0, 1'b1);

    // Back-to-back: restart in every done cycle.
    for (int it = 0; it < 1000; it++) begin
      ra = rand_fe();
      rb = rand_fe();
      run_op(ra, rb, ref_sub(ra, rb), 1'b1);
    end

    repeat (20) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_done outstanding=%0d exp 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
